ifetch_queue: RTL and testbench
===============================

IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter ADDR_W, default 32: fetch address width.
REQ-002 Parameter INSTR_W, default 32: instruction width.
REQ-003 Parameter DEPTH, default 4: queue entries and maximum in-flight requests; power of two, at least 2.
REQ-004 Parameter RESET_PC, default 0: first fetch address; word-aligned.
REQ-005 clk  input  1  single clock; all state on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_addr  output  ADDR_W  fetch address.
REQ-009 imem_req_ready  input  1  memory accepts the request.
REQ-010 imem_rsp_valid  input  1  response valid; responses arrive in order, one per accepted request, at least 1 cycle after acceptance.
REQ-011 imem_rsp_data  input  INSTR_W  fetched instruction.
REQ-012 dec_valid  output  1  queue head valid toward decode.
REQ-013 dec_ready  input  1  decode consumes the head.
REQ-014 dec_instr  output  INSTR_W  head instruction.
REQ-015 dec_pc  output  ADDR_W  head instruction address.
REQ-016 redirect  input  1  branch/jump taken; flushes the queue.
REQ-017 redirect_pc  input  ADDR_W  new fetch address; bits [1:0] ignored and treated as 0.

Function
REQ-018 A request is accepted when imem_req_valid and imem_req_ready are both 1; on acceptance, fetch_pc advances by 4, modulo 2^ADDR_W.
REQ-019 imem_req_addr shall equal fetch_pc at all times.
REQ-020 imem_req_valid shall be 1 iff rst=1 and redirect=0 and occupancy+inflight < DEPTH; the queue shall never overflow.
REQ-021 inflight counts accepted requests minus received responses, including responses that are discarded.
REQ-022 A kept response shall be written to the tail with pc=rsp_pc; rsp_pc then advances by 4, modulo 2^ADDR_W.
REQ-023 dec_valid shall equal occupancy != 0.
REQ-024 dec_instr and dec_pc shall show the head entry; the head pops when dec_valid and dec_ready are both 1.
REQ-025 Latency: a response kept in cycle t into an empty queue shall appear with dec_valid=1 in cycle t+1; there is no same-cycle bypass.
REQ-026 A push and a pop in the same cycle shall leave occupancy unchanged; this is legal both at full and at occupancy 1.
REQ-027 While dec_valid=1 and dec_ready=0, dec_instr and dec_pc shall hold stable.
REQ-028 Redirect cycle: imem_req_valid=0 and dec_valid=0, and any response arriving in that cycle is dropped.
REQ-029 At the next edge after a redirect, occupancy shall become 0 and fetch_pc and rsp_pc shall load {redirect_pc[ADDR_W-1:2],2'b00}.
REQ-030 At the same edge, discard_cnt shall load inflight minus any response arriving in the redirect cycle.
REQ-031 While discard_cnt>0, each arriving response shall be dropped and discard_cnt decremented; it shall not be pushed and rsp_pc shall not advance.
REQ-032 New requests may issue during discard.
REQ-033 Redirects in back-to-back cycles are legal; the last one wins, and discard_cnt is recomputed each time.
REQ-034 Credit rule: occupancy+inflight <= DEPTH shall hold in every cycle.

Reset
REQ-035 While rst=0: imem_req_valid=0, dec_valid=0, dec_instr=0, dec_pc=0, imem_req_addr=RESET_PC, and occupancy, inflight and discard_cnt are all 0.
REQ-036 fetch_pc and rsp_pc shall reset to RESET_PC.
REQ-037 imem_req_valid shall assert in the first cycle with rst=1.
REQ-038 Reset asserted mid-operation shall abandon all in-flight requests; the instruction memory shall be reset by the same rst.

Structure
REQ-039 ADDR_SIZE, INSTR_SIZE and the PC increment constant (4) belong in the shared defines file; the parameter defaults shall be taken from them.
REQ-040 Queue storage shall be one sub-module, fetch_fifo, parametrised by width (ADDR_W+INSTR_W) and DEPTH.
REQ-041 fetch_fifo shall provide occupancy, push, pop and clear.
REQ-042 The credit, discard and PC logic shall live in ifetch_queue.

Verification
REQ-043 Reset release, imem_req_ready=1, 1-cycle responses, dec_ready=1 -> dec_pc sequence 0,4,8,12..., one per cycle in steady state.
REQ-044 dec_ready=0, DEPTH=4 -> exactly 4 requests accepted, then imem_req_valid=0; dec_ready=1 -> one new request issues per pop.
REQ-045 3 requests in flight, redirect with redirect_pc=0x103 -> 3 responses dropped, next dec_pc=0x100, no stale instruction reaches decode.
REQ-046 Response and redirect in the same cycle with 2 in flight -> discard_cnt=1, first post-redirect dec_pc equals the redirect target.
REQ-047 ADDR_W=8, RESET_PC=0xF8 -> dec_pc sequence 0xF8,0xFC,0x00.
REQ-048 rst driven to 0 with 2 in flight and queue full -> outputs reach reset values immediately without a clock edge; after release the first request address is RESET_PC.

Source files
------------

// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg
//   Shared defines for the instruction-fetch queue slice.
//   ADDR_SIZE / INSTR_SIZE are the default fetch-address and instruction
//   widths. PC_INC is the byte step between sequential fetch addresses.
//   The counter helper sizes occupancy/credit counters for a given depth.
package ifetch_queue_pkg;

  localparam int ADDR_SIZE  = 32;
  localparam int INSTR_SIZE = 32;
  localparam int PC_INC     = 4;

  // Width of a counter that must hold every value 0..depth inclusive.
  function automatic int countWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// fetch_fifo
//   Circular buffer holding fetched {pc, instruction} entries for decode.
//   Ports:
//     clk, rst       clock, asynchronous active-low reset
//     clear          drop every entry (takes priority over push/pop)
//     push/pushData  write pushData at the tail
//     pop            retire the head entry
//     headData       current head entry (meaningful while occupancy != 0)
//     occupancy      number of valid entries, 0..DEPTH
//   The caller guarantees push never targets a full buffer and pop never
//   targets an empty one. A push and a pop in the same cycle leave the
//   occupancy unchanged.
module fetch_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int WIDTH = ADDR_SIZE + INSTR_SIZE,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             pushData,
  input  logic                         pop,
  output logic [WIDTH-1:0]             headData,
  output logic [countWidth(DEPTH)-1:0] occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = countWidth(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;

  // NOTE: storage has no reset; an entry is only observed after a push has
  // written it, and leaving the array reset-free lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem[wrPtr] <= pushData;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so that
  // every read in this block sees the value from before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign headData  = mem[rdPtr];
  assign occupancy = count;

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue
//   Decoupled instruction-fetch front end. Issues sequential fetch requests,
//   buffers in-order responses for decode, and flushes on redirect.
//   Ports:
//     clk, rst                    clock, asynchronous active-low reset
//     imem_req_valid/addr/ready   fetch request handshake toward memory
//     imem_rsp_valid/data         in-order responses, one per accepted request
//     dec_valid/ready/instr/pc    queue head toward decode
//     redirect, redirect_pc       taken branch/jump; flushes and re-steers
//   Credit: a request is only issued while queued entries plus outstanding
//   requests are below DEPTH, so every response always has a free slot.
//   After a redirect the responses still owed for older requests are counted
//   in discardCnt and dropped as they arrive.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_SIZE,
  parameter int                INSTR_W  = INSTR_SIZE,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int                CNT_W      = countWidth(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(PC_INC);
  localparam logic [CNT_W:0]    CREDIT_MAX = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0]         fetchPc;
  logic [ADDR_W-1:0]         rspPc;
  logic [ADDR_W-1:0]         redirectTarget;
  logic [CNT_W-1:0]          inflight;
  logic [CNT_W-1:0]          discardCnt;
  logic [CNT_W-1:0]          occupancy;
  logic [CNT_W:0]            creditUsed;
  logic                      accept;
  logic                      rspKeep;
  logic                      headValid;
  logic                      pop;
  logic [ADDR_W+INSTR_W-1:0] headEntry;

  assign redirectTarget = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign creditUsed     = {1'b0, occupancy} + {1'b0, inflight};

  // rst appears here so the request drops the moment reset asserts, with no
  // clock edge needed, and rises in the first cycle after release.
  assign imem_req_valid = rst && !redirect && (creditUsed < CREDIT_MAX);
  assign imem_req_addr  = fetchPc;
  assign accept         = imem_req_valid && imem_req_ready;

  // Responses are stale while older requests are still being drained, and
  // anything arriving in the redirect cycle itself belongs to the old path.
  assign rspKeep = imem_rsp_valid && !redirect && (discardCnt == '0);

  assign headValid = (occupancy != '0);
  assign dec_valid = headValid && !redirect;
  assign pop       = dec_valid && dec_ready;

  // Zeroed while empty so reset (which empties the queue) shows 0 on decode.
  assign {dec_pc, dec_instr} = headValid ? headEntry : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc    <= RESET_PC;
      rspPc      <= RESET_PC;
      inflight   <= '0;
      discardCnt <= '0;
    end else begin
      // Every response retires one outstanding request, kept or dropped.
      inflight <= inflight + CNT_W'(accept) - CNT_W'(imem_rsp_valid);

      if (redirect) begin
        fetchPc    <= redirectTarget;
        rspPc      <= redirectTarget;
        // All requests still outstanding after this edge are on the old path.
        discardCnt <= inflight - CNT_W'(imem_rsp_valid);
      end else begin
        if (accept)  fetchPc <= fetchPc + PC_STEP;
        if (rspKeep) rspPc   <= rspPc + PC_STEP;
        if (imem_rsp_valid && (discardCnt != '0)) begin
          discardCnt <= discardCnt - CNT_W'(1);
        end
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ADDR_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (rspKeep),
    .pushData  ({rspPc, imem_rsp_data}),
    .pop       (pop),
    .headData  (headEntry),
    .occupancy (occupancy)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue
//   Drives ifetch_queue with directed and randomized traffic against a
//   behavioural model: requests are tagged with a fetch epoch that advances
//   on every redirect, responses from an older epoch (or arriving in the
//   redirect cycle) are never delivered, and decode must see the addresses
//   target, target+4, ... of the current epoch with instruction memFn(pc).
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        dec_valid;
  logic        dec_ready   = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = '0;

  ifetch_queue #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nBad    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memFn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  // Memory + reference model state
  req_t        pend[$];
  int          occ = 0;
  int          outstanding = 0;
  int          epoch = 0;
  int          cyc = 0;
  logic [31:0] expFetch = RESET_PC;
  logic [31:0] expPc = RESET_PC;

  // Stimulus knobs for the next cycle
  bit          readyNext = 0;
  bit          decReadyNext = 0;
  bit          redirNext = 0;
  bit          memHold = 0;
  logic [31:0] redirPcNext = '0;
  int          rspPct = 100;
  int          maxExtra = 0;

  // Observations
  int          accCnt = 0;
  int          popCnt = 0;
  bit          watchFirst = 0;
  logic [31:0] firstPop = '1;
  logic [31:0] popLog[$];

  // One cycle: drive inputs, check outputs against the model, advance model.
  task automatic body();
    bit   rspFire;
    bit   expReqValid;
    bit   expDecValid;
    bit   acc;
    bit   popNow;
    int   d;
    req_t r;
    redirect       = redirNext;
    redirect_pc    = redirPcNext;
    imem_req_ready = readyNext;
    dec_ready      = decReadyNext;
    rspFire        = 1'b0;
    if (pend.size() > 0 && !memHold && pend[0].due <= cyc &&
        int'($urandom_range(99)) < rspPct) begin
      rspFire = 1'b1;
    end
    imem_rsp_valid = rspFire;
    if (rspFire) imem_rsp_data = memFn(pend[0].addr);
    else         imem_rsp_data = $urandom();
    #1;
    expReqValid = !redirNext && (occ + outstanding < DEPTH);
    expDecValid = !redirNext && (occ != 0);
    check("req_valid", imem_req_valid, expReqValid);
    check("req_addr", imem_req_addr, expFetch);
    check("dec_valid", dec_valid, expDecValid);
    if (expDecValid) begin
      check("dec_pc", dec_pc, expPc);
      check("dec_instr", dec_instr, memFn(expPc));
    end
    acc    = expReqValid && readyNext;
    popNow = expDecValid && decReadyNext;
    if (popNow) begin
      popLog.push_back(dec_pc);
      popCnt++;
      if (watchFirst) begin
        firstPop   = dec_pc;
        watchFirst = 0;
      end
      expPc += 4;
      occ--;
    end
    if (rspFire) begin
      r = pend.pop_front();
      outstanding--;
      if (!redirNext && r.epoch == epoch) occ++;
    end
    if (acc) begin
      d = cyc + 1 + int'($urandom_range(maxExtra));
      pend.push_back('{addr: expFetch, epoch: epoch, due: d});
      outstanding++;
      accCnt++;
      expFetch += 4;
    end
    if (redirNext) begin
      epoch++;
      occ        = 0;
      expFetch   = {redirPcNext[31:2], 2'b00};
      expPc      = {redirPcNext[31:2], 2'b00};
      watchFirst = 1;
      popLog.delete();
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    body();
  endtask

  // Asserts reset asynchronously at the current time (away from any edge),
  // checks the reset values at once, then releases on a falling edge.
  task automatic applyReset();
    rst            = 1'b0;
    redirect       = 1'b0;
    redirNext      = 0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    dec_ready      = 1'b0;
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_dec_valid", dec_valid, 0);
    check("rst_dec_instr", dec_instr, 0);
    check("rst_dec_pc", dec_pc, 0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    pend.delete();
    occ         = 0;
    outstanding = 0;
    epoch++;
    expFetch    = RESET_PC;
    expPc       = RESET_PC;
    watchFirst  = 0;
    popLog.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_req_valid", imem_req_valid, 1);
    check("rel_req_addr", imem_req_addr, RESET_PC);
    body();
  endtask

  initial begin
    bit prevRedir;
    #2;

    // Streaming: one decode per cycle, sequential pcs from RESET_PC
    readyNext = 1; decReadyNext = 1; rspPct = 100; maxExtra = 0; memHold = 0;
    applyReset();
    repeat (9) step();
    popCnt = 0;
    repeat (20) step();
    check("a_steady_pops", popCnt, 20);
    check("a_seq_len", popLog.size() >= 4, 1);
    if (popLog.size() >= 4) begin
      for (int i = 0; i < 4; i++) check("a_seq_pc", popLog[i], 32'(i * 4));
    end

    // Stalled decode: credit caps issue at DEPTH, one refill per pop
    readyNext = 1; decReadyNext = 0;
    accCnt = 0;
    applyReset();
    repeat (11) step();
    check("b_accepts", accCnt, DEPTH);
    check("b_req_valid_full", imem_req_valid, 0);
    accCnt = 0;
    decReadyNext = 1;
    step();
    decReadyNext = 0;
    repeat (6) step();
    check("b_accept_per_pop", accCnt, 1);

    // Redirect with three requests outstanding, unaligned target
    readyNext = 1; decReadyNext = 1; memHold = 1;
    applyReset();
    repeat (2) step();
    readyNext = 0; redirNext = 1; redirPcNext = 32'h0000_0103; firstPop = '1;
    step();
    redirNext = 0; memHold = 0; readyNext = 1;
    repeat (25) step();
    check("c_first_pc", firstPop, 32'h0000_0100);

    // Response lands in the redirect cycle with two outstanding
    memHold = 1; readyNext = 1;
    applyReset();
    step();
    readyNext = 0; redirNext = 1; redirPcNext = 32'h2000_0040; memHold = 0; firstPop = '1;
    step();
    redirNext = 0; readyNext = 1;
    repeat (25) step();
    check("d_first_pc", firstPop, 32'h2000_0040);

    // Address wrap at the top of the address space
    redirNext = 1; redirPcNext = 32'hFFFF_FFF9;
    step();
    redirNext = 0;
    repeat (20) step();
    check("e_wrap_len", popLog.size() >= 3, 1);
    if (popLog.size() >= 3) begin
      check("e_wrap_pc0", popLog[0], 32'hFFFF_FFF8);
      check("e_wrap_pc1", popLog[1], 32'hFFFF_FFFC);
      check("e_wrap_pc2", popLog[2], 32'h0000_0000);
    end

    // Randomized traffic with occasional back-to-back redirects
    rspPct = 60; maxExtra = 3; prevRedir = 0;
    for (int i = 0; i < 3000; i++) begin
      readyNext    = ($urandom_range(99) < 70);
      decReadyNext = ($urandom_range(99) < 70);
      redirNext    = prevRedir ? ($urandom_range(99) < 30) : ($urandom_range(99) < 3);
      redirPcNext  = $urandom();
      prevRedir    = redirNext;
      step();
    end
    redirNext = 0;

    // Reset mid-operation with a non-empty queue and requests outstanding
    rspPct = 100; maxExtra = 0; memHold = 0; readyNext = 1; decReadyNext = 0;
    repeat (3) step();
    memHold = 1; decReadyNext = 1;
    step();
    decReadyNext = 0;
    repeat (3) step();
    applyReset();
    memHold = 0; decReadyNext = 1;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
